// File: rtl/as6s_vp_buffer_wr_credit_feeder_pkg.sv
// ============================================================================
// as6s_vp_buffer_wr_credit_feeder_pkg : shared defaults and credit helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package as6s_vp_buffer_wr_credit_feeder_pkg;

  localparam int VPB_DATA_WIDTH = 128;
  localparam int VPB_ADDR_WIDTH = 4;
  localparam int CRD_W          = VPB_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    CRD_HOLD = 2'd0,
    CRD_TAKE = 2'd1,
    CRD_GIVE = 2'd2
  } crd_op_e;

  // An issue and a return in the same cycle cancel out.
  function automatic crd_op_e crd_op(input logic issue, input logic ret);
    crd_op_e op;
    op = CRD_HOLD;
    if (issue && !ret) op = CRD_TAKE;
    if (ret && !issue) op = CRD_GIVE;
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/as6s_sync_pipe_clr.sv
// ============================================================================
// as6s_sync_pipe_clr : DELAY_CYCLES x BUS_WIDTH register pipeline, sync clear
// Rev 1.0
// ============================================================================
`default_nettype none

module as6s_sync_pipe_clr #(
  parameter int BUS_WIDTH    = 1,
  parameter int DELAY_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic [BUS_WIDTH-1:0] d_i,
  output logic [BUS_WIDTH-1:0] q_o
);

  logic [BUS_WIDTH-1:0] stage_q [DELAY_CYCLES];

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int i = 0; i < DELAY_CYCLES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DELAY_CYCLES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DELAY_CYCLES-1];

endmodule

`default_nettype wire

// File: rtl/as6s_vp_buffer_wr_credit_feeder.sv
// ============================================================================
// as6s_vp_buffer_wr_credit_feeder : credit-based, pipelined write feeder for
// the vp_buffer FIFO (2-entry skid buffer + credit counter + wr pipeline)
// Rev 1.0
// ============================================================================
`default_nettype none

module as6s_vp_buffer_wr_credit_feeder
  import as6s_vp_buffer_wr_credit_feeder_pkg::*;
#(
  parameter int DATA_WIDTH    = VPB_DATA_WIDTH,
  parameter int ADDR_WIDTH    = VPB_ADDR_WIDTH,
  parameter int FIFO_DEEP     = 1 << ADDR_WIDTH,
  parameter int WR_PIPE_STAGE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  domain_clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  input  logic                  full,
  input  logic                  crd_ret,
  output logic [ADDR_WIDTH:0]   crd_avail,
  output logic                  ovf_int,
  output logic                  crd_err_int
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CRD_MAX = CNT_W'(FIFO_DEEP);

  logic                  clr;
  logic                  accept;
  logic                  issue;

  logic                  head_valid_q, head_valid_d;
  logic [DATA_WIDTH-1:0] head_data_q,  head_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
  logic                  in_ready_q;
  logic [CNT_W-1:0]      crd_cnt_q,    crd_cnt_d;
  logic                  crd_err_q,    crd_err_d;
  logic                  ovf_q;
  logic [DATA_WIDTH:0]   pipe_out;

  assign clr    = rst | domain_clear;
  assign accept = in_valid & in_ready_q;
  assign issue  = head_valid_q & (crd_cnt_q != '0);

  always_comb begin
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    // Head frees up this cycle: skid has priority to keep FIFO order.
    if (!head_valid_q || issue) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        head_valid_d = accept;
        if (accept) head_data_d = in_data;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_comb begin
    crd_cnt_d = crd_cnt_q;
    crd_err_d = 1'b0;
    case (crd_op(issue, crd_ret))
      CRD_TAKE: crd_cnt_d = crd_cnt_q - 1'b1;
      CRD_GIVE: begin
        if (crd_cnt_q == CRD_MAX) crd_err_d = 1'b1;
        else                      crd_cnt_d = crd_cnt_q + 1'b1;
      end
      default:  crd_cnt_d = crd_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
      crd_cnt_q    <= CRD_MAX;
      crd_err_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= ~skid_valid_d;
      crd_cnt_q    <= crd_cnt_d;
      crd_err_q    <= crd_err_d;
      ovf_q        <= wr_en & full;
    end
  end

  as6s_sync_pipe_clr #(
    .BUS_WIDTH    (DATA_WIDTH + 1),
    .DELAY_CYCLES (WR_PIPE_STAGE)
  ) u_wr_pipe (
    .clk   (clk),
    .rst   (rst),
    .clr_i (domain_clear),
    .d_i   ({issue, head_data_q}),
    .q_o   (pipe_out)
  );

  assign wr_en       = pipe_out[DATA_WIDTH];
  assign wr_data     = pipe_out[DATA_WIDTH-1:0];
  assign in_ready    = in_ready_q;
  assign crd_avail   = crd_cnt_q;
  assign ovf_int     = ovf_q;
  assign crd_err_int = crd_err_q;

endmodule

`default_nettype wire

// File: tb/tb_as6s_vp_buffer_wr_credit_feeder.sv
// ============================================================================
// tb_as6s_vp_buffer_wr_credit_feeder : directed + randomized self-checking bench
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_as6s_vp_buffer_wr_credit_feeder;

  localparam int DW = 128;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          domain_clear = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          full = 1'b0;
  logic          crd_ret = 1'b0;
  logic [AW:0]   crd_avail;
  logic          ovf_int;
  logic          crd_err_int;

  int checks = 0;
  int errors = 0;
  int nwr = 0;
  logic [DW-1:0] expq [$];

  always #5 clk = ~clk;

  as6s_vp_buffer_wr_credit_feeder #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .FIFO_DEEP     (DEPTH),
    .WR_PIPE_STAGE (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .domain_clear (domain_clear),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .full         (full),
    .crd_ret      (crd_ret),
    .crd_avail    (crd_avail),
    .ovf_int      (ovf_int),
    .crd_err_int  (crd_err_int)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; accepted words feed the scoreboard, writes are matched in order.
  task automatic tick();
    if (in_valid && in_ready) expq.push_back(in_data);
    @(posedge clk);
    #1;
    if (wr_en === 1'b1) begin
      nwr++;
      check("wr_expected", DW'(expq.size() != 0), DW'(1));
      if (expq.size() != 0) check("wr_order", wr_data, expq.pop_front());
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    crd_ret  = 1'b0;
    full     = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    expq.delete();
  endtask

  task automatic send_and_drain(input int n, input int base);
    int acc;
    acc = 0;
    for (int i = 0; i < n + 20 && acc < n; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(base + acc);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, first_drop, nwr0;
    int occ, prev_occ, prev_crd, prev_wr, cur_wr, cur_crd;

    // Reset state
    do_reset();
    check("rst_in_ready", DW'(in_ready), DW'(1));
    check("rst_wr_en", DW'(wr_en), DW'(0));
    check("rst_wr_data", wr_data, '0);
    check("rst_crd", DW'(crd_avail), DW'(16));
    check("rst_ovf", DW'(ovf_int), DW'(0));
    check("rst_crd_err", DW'(crd_err_int), DW'(0));

    // Single word: accept at T, wr_en at T+3
    in_valid = 1'b1;
    in_data  = DW'(8'hA5);
    tick();
    in_valid = 1'b0;
    check("sw_t1_wr_en", DW'(wr_en), DW'(0));
    tick();
    check("sw_t2_crd", DW'(crd_avail), DW'(15));
    check("sw_t2_wr_en", DW'(wr_en), DW'(0));
    tick();
    check("sw_t3_wr_en", DW'(wr_en), DW'(1));
    check("sw_t3_wr_data", wr_data, DW'(8'hA5));
    tick();
    check("sw_t4_wr_en", DW'(wr_en), DW'(0));
    crd_ret = 1'b1;
    tick();
    crd_ret = 1'b0;
    check("sw_ret_crd", DW'(crd_avail), DW'(16));

    // Burst of 20 with no returns
    do_reset();
    nwr = 0;
    acc = 0;
    first_drop = -1;
    for (int i = 0; i < 40; i++) begin
      if (!in_ready && first_drop < 0) first_drop = acc;
      in_valid = (acc < 20);
      in_data  = DW'(acc + 1);
      if (in_valid && in_ready) acc++;
      tick();
    end
    check("burst_nwr", DW'(nwr), DW'(16));
    check("burst_drop_at", DW'(first_drop), DW'(18));
    check("burst_crd", DW'(crd_avail), DW'(0));
    check("burst_in_ready", DW'(in_ready), DW'(0));
    for (int k = 0; k < 4; k++) begin
      crd_ret  = 1'b1;
      in_valid = (acc < 20);
      in_data  = DW'(acc + 1);
      if (in_valid && in_ready) acc++;
      tick();
      crd_ret = 1'b0;
      in_valid = (acc < 20);
      in_data  = DW'(acc + 1);
      if (in_valid && in_ready) acc++;
      tick();
    end
    for (int i = 0; i < 15; i++) begin
      in_valid = (acc < 20);
      in_data  = DW'(acc + 1);
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("burst2_nwr", DW'(nwr), DW'(20));
    check("burst2_acc", DW'(acc), DW'(20));
    check("burst2_in_ready", DW'(in_ready), DW'(1));
    check("burst2_crd", DW'(crd_avail), DW'(0));
    check("burst2_sb_empty", DW'(expq.size()), DW'(0));

    // Issue and return in the same cycle at crd_avail=7
    do_reset();
    send_and_drain(9, 32'h100);
    check("sim_pre_crd", DW'(crd_avail), DW'(7));
    in_valid = 1'b1;
    in_data  = DW'(8'h77);
    tick();
    in_valid = 1'b0;
    crd_ret  = 1'b1;
    check("sim_t1_crd", DW'(crd_avail), DW'(7));
    tick();
    crd_ret = 1'b0;
    check("sim_t2_crd", DW'(crd_avail), DW'(7));
    tick();
    check("sim_t3_crd", DW'(crd_avail), DW'(7));
    check("sim_t3_wr_en", DW'(wr_en), DW'(1));

    // Credit return beyond depth
    do_reset();
    crd_ret = 1'b1;
    tick();
    crd_ret = 1'b0;
    check("err_crd_sat", DW'(crd_avail), DW'(16));
    check("err_pulse", DW'(crd_err_int), DW'(1));
    tick();
    check("err_pulse_end", DW'(crd_err_int), DW'(0));
    check("err_crd_hold", DW'(crd_avail), DW'(16));

    // Write while full
    in_valid = 1'b1;
    in_data  = DW'(8'h5A);
    full     = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("ovf_t2", DW'(ovf_int), DW'(0));
    tick();
    check("ovf_t3_wr_en", DW'(wr_en), DW'(1));
    tick();
    check("ovf_t4", DW'(ovf_int), DW'(1));
    full = 1'b0;
    tick();
    check("ovf_t5", DW'(ovf_int), DW'(0));

    // Clear with words held in head/skid and in the pipeline
    do_reset();
    send_and_drain(14, 32'h200);
    check("clr_pre_crd", DW'(crd_avail), DW'(2));
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(32'hC0 + k);
      tick();
    end
    check("clr_pre_crd0", DW'(crd_avail), DW'(0));
    in_data      = DW'(32'hC3);
    domain_clear = 1'b1;
    tick();
    domain_clear = 1'b0;
    in_valid     = 1'b0;
    expq.delete();
    check("clr_wr_en", DW'(wr_en), DW'(0));
    check("clr_in_ready", DW'(in_ready), DW'(1));
    check("clr_crd", DW'(crd_avail), DW'(16));
    nwr0 = nwr;
    for (int i = 0; i < 10; i++) tick();
    check("clr_no_ghost", DW'(nwr - nwr0), DW'(0));

    // Random traffic against a FIFO model with credit conservation
    do_reset();
    occ = 0;
    prev_occ = 0;
    prev_crd = 16;
    prev_wr = 0;
    for (int t = 0; t < 800; t++) begin
      cur_wr  = int'(wr_en);
      cur_crd = int'(crd_avail);
      if (t > 0)
        check("rnd_conserve", DW'(prev_crd + prev_occ + prev_wr + cur_wr), DW'(DEPTH));
      check("rnd_ovf", DW'(ovf_int), DW'(0));
      if (cur_wr != 0) check("rnd_no_overflow", DW'(occ < DEPTH), DW'(1));
      full     = (occ >= DEPTH);
      crd_ret  = (occ > 0) && ((t >= 650) || ($urandom_range(0, 99) < 40));
      in_valid = (t < 650) && ($urandom_range(0, 99) < 70);
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      prev_crd = cur_crd;
      prev_occ = occ;
      prev_wr  = cur_wr;
      occ      = occ + cur_wr - int'(crd_ret);
      tick();
    end
    in_valid = 1'b0;
    crd_ret  = 1'b0;
    check("rnd_sb_empty", DW'(expq.size()), DW'(0));
    check("rnd_final_crd", DW'(crd_avail), DW'(16));
    check("rnd_final_occ", DW'(occ), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
